// File: rtl/ppi_pkg.sv
// Shared field positions, register offsets and status packing for the ppi_nport
// parallel port block and its per-port channel.
package ppi_pkg;

    localparam int CTRL_DIR  = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IE   = 2;

    localparam int STAT_IBF  = 3;
    localparam int STAT_OBF  = 4;
    localparam int STAT_INTR = 5;

    localparam int REG_DATA = 0;
    localparam int REG_CTRL = 1;

    typedef logic [2:0] ctrl_t;

    // Ports come out of reset as mode-0 inputs so nothing drives the pins.
    localparam ctrl_t CTRL_RST = 3'b001;

    function automatic logic [5:0] pack_status(input ctrl_t ctrl, input logic ibf,
                                               input logic obf, input logic intr);
        logic [5:0] s;
        s            = '0;
        s[2:0]       = ctrl;
        s[STAT_IBF]  = ibf;
        s[STAT_OBF]  = obf;
        s[STAT_INTR] = intr;
        return s;
    endfunction

endpackage

// File: rtl/ppi_port_channel.sv
// One PPI port: pin/strobe synchronisers, input and output latches, control
// register and the mode-1 handshake flags.
module ppi_port_channel
    import ppi_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_data,
    input  logic             wr_ctrl,
    input  logic             rd_data,
    input  logic [WIDTH-1:0] pin,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] port_oe,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic [WIDTH-1:0] rd_val,
    output logic [WIDTH-1:0] status
);

    logic [WIDTH-1:0] pin_p0, pin_p1;
    logic             stb_p0, stb_p1, stb_p2;
    logic             ack_p0, ack_p1, ack_p2;
    ctrl_t            ctrl;
    logic [WIDTH-1:0] out_latch, in_latch;
    logic             done;

    ctrl_t            ctrl_nxt;
    logic [WIDTH-1:0] out_nxt, in_nxt;
    logic             ibf_nxt, obf_nxt, done_nxt, intr_nxt;
    logic             m1_in, m1_out, stb_fall, ack_fall, ack_rise;

    assign m1_in    = ctrl[CTRL_MODE] &  ctrl[CTRL_DIR];
    assign m1_out   = ctrl[CTRL_MODE] & ~ctrl[CTRL_DIR];
    // Edges are taken between the second sync stage and its delayed copy.
    assign stb_fall =  stb_p2 & ~stb_p1;
    assign ack_fall =  ack_p2 & ~ack_p1;
    assign ack_rise = ~ack_p2 &  ack_p1;

    always_comb begin
        ctrl_nxt = ctrl;
        out_nxt  = out_latch;
        in_nxt   = in_latch;
        ibf_nxt  = ibf;
        obf_nxt  = ~obf_n;
        done_nxt = done;
        if (wr_ctrl) begin
            ctrl_nxt = din[2:0];
            out_nxt  = '0;
            ibf_nxt  = 1'b0;
            obf_nxt  = 1'b0;
            done_nxt = 1'b0;
        end else begin
            // A CPU write outranks an acknowledge edge arriving in the same cycle.
            if (wr_data) begin
                out_nxt  = din;
                done_nxt = 1'b0;
                if (m1_out) obf_nxt = 1'b1;
            end else if (m1_out) begin
                if (ack_fall) obf_nxt = 1'b0;
                if (ack_rise && obf_n) done_nxt = 1'b1;
            end
            if (m1_in) begin
                if (rd_data) ibf_nxt = 1'b0;
                if (stb_fall) begin
                    in_nxt  = pin_p1;
                    ibf_nxt = 1'b1;
                end
            end
        end
        intr_nxt = ctrl_nxt[CTRL_IE] & (ibf_nxt | done_nxt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pin_p0    <= '0;
            pin_p1    <= '0;
            stb_p0    <= 1'b1;
            stb_p1    <= 1'b1;
            stb_p2    <= 1'b1;
            ack_p0    <= 1'b1;
            ack_p1    <= 1'b1;
            ack_p2    <= 1'b1;
            ctrl      <= CTRL_RST;
            out_latch <= '0;
            in_latch  <= '0;
            ibf       <= 1'b0;
            obf_n     <= 1'b1;
            done      <= 1'b0;
            intr      <= 1'b0;
        end else begin
            pin_p0    <= pin;
            pin_p1    <= pin_p0;
            stb_p0    <= stb_n;
            stb_p1    <= stb_p0;
            stb_p2    <= stb_p1;
            ack_p0    <= ack_n;
            ack_p1    <= ack_p0;
            ack_p2    <= ack_p1;
            ctrl      <= ctrl_nxt;
            out_latch <= out_nxt;
            in_latch  <= in_nxt;
            ibf       <= ibf_nxt;
            obf_n     <= ~obf_nxt;
            done      <= done_nxt;
            intr      <= intr_nxt;
        end
    end

    assign port_out = out_latch;
    assign port_oe  = {WIDTH{~ctrl[CTRL_DIR]}};
    assign rd_val   = ctrl[CTRL_DIR] ? (ctrl[CTRL_MODE] ? in_latch : pin_p1) : out_latch;
    assign status   = WIDTH'(pack_status(ctrl, ibf, ~obf_n, intr));

endmodule

// File: rtl/ppi_nport.sv
// NPORTS-wide programmable peripheral interface: CPU access commit detection,
// register decode and read mux around one ppi_port_channel per port.
module ppi_nport
    import ppi_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NPORTS = 2,
    localparam int ADDR_W = $clog2(2*NPORTS)
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cs_n,
    input  logic                    rd_n,
    input  logic                    wr_n,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    d_oe,
    input  logic [NPORTS*WIDTH-1:0] port_in,
    output logic [NPORTS*WIDTH-1:0] port_out,
    output logic [NPORTS*WIDTH-1:0] port_oe,
    input  logic [NPORTS-1:0]       stb_n,
    input  logic [NPORTS-1:0]       ack_n,
    output logic [NPORTS-1:0]       ibf,
    output logic [NPORTS-1:0]       obf_n,
    output logic [NPORTS-1:0]       intr
);

    logic             rd_req, wr_req, rd_req_q, wr_req_q;
    logic             rd_commit, wr_commit;
    logic [WIDTH-1:0] rd_mux;
    logic [WIDTH-1:0] ch_data   [NPORTS];
    logic [WIDTH-1:0] ch_status [NPORTS];

    // Both strobes low together is not a valid access and never commits.
    assign rd_req    = ~cs_n & ~rd_n &  wr_n;
    assign wr_req    = ~cs_n & ~wr_n &  rd_n;
    assign rd_commit = rd_req & ~rd_req_q;
    assign wr_commit = wr_req & ~wr_req_q;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(2*p + REG_DATA);
        localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(2*p + REG_CTRL);

        ppi_port_channel #(.WIDTH(WIDTH)) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .din      (din),
            .wr_data  (wr_commit && (addr == A_DATA)),
            .wr_ctrl  (wr_commit && (addr == A_CTRL)),
            .rd_data  (rd_commit && (addr == A_DATA)),
            .pin      (port_in[p*WIDTH +: WIDTH]),
            .stb_n    (stb_n[p]),
            .ack_n    (ack_n[p]),
            .port_out (port_out[p*WIDTH +: WIDTH]),
            .port_oe  (port_oe[p*WIDTH +: WIDTH]),
            .ibf      (ibf[p]),
            .obf_n    (obf_n[p]),
            .intr     (intr[p]),
            .rd_val   (ch_data[p]),
            .status   (ch_status[p])
        );
    end

    // Addresses past the last port match nothing and read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (addr == ADDR_W'(2*p + REG_DATA)) rd_mux = ch_data[p];
            if (addr == ADDR_W'(2*p + REG_CTRL)) rd_mux = ch_status[p];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            dout     <= '0;
            d_oe     <= 1'b0;
        end else begin
            rd_req_q <= rd_req;
            wr_req_q <= wr_req;
            if (rd_commit) dout <= rd_mux;
            d_oe     <= rd_commit | (d_oe & ~cs_n & ~rd_n);
        end
    end

endmodule

// File: tb/tb_ppi_nport.sv
// Bench for ppi_nport: register table, hand-timed handshake/collision sequences,
// then random CPU traffic against a register-level model.
module tb_ppi_nport;

    localparam int W  = 8;
    localparam int NP = 3;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cs_n, rd_n, wr_n;
    logic [AW-1:0]     addr;
    logic [W-1:0]      din, dout;
    logic              d_oe;
    logic [NP*W-1:0]   port_in, port_out, port_oe;
    logic [NP-1:0]     stb_n, ack_n, ibf, obf_n, intr;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ppi_nport #(.WIDTH(W), .NPORTS(NP)) dut (
        .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .din(din), .dout(dout), .d_oe(d_oe),
        .port_in(port_in), .port_out(port_out), .port_oe(port_oe),
        .stb_n(stb_n), .ack_n(ack_n), .ibf(ibf), .obf_n(obf_n), .intr(intr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        tick();
        addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
        tick();
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [W-1:0] d);
        tick();
        addr = a; cs_n = 1'b0; rd_n = 1'b0;
        tick();
        d = dout;
        check("d_oe_during_read", 32'(d_oe), 32'd1);
        cs_n = 1'b1; rd_n = 1'b1;
    endtask

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t tbl [15];

    logic [2:0]   m_ctrl [NP];
    logic [W-1:0] m_out  [NP];
    logic         m_obf  [NP];

    initial begin
        logic [W-1:0]    rv, exp_rd;
        logic [NP*W-1:0] e_out, e_oe;
        logic [NP-1:0]   e_obfn;
        int              p, is_wr, sel;
        logic [AW-1:0]   a;
        logic [W-1:0]    d;

        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = '0; din = '0;
        port_in = '0; stb_n = '1; ack_n = '1;
        reset_n = 1'b0;
        tick(); tick(); tick();
        check("rst_port_out", 32'(port_out), 32'h0);
        check("rst_port_oe", 32'(port_oe), 32'h0);
        check("rst_ibf", 32'(ibf), 32'h0);
        check("rst_obf_n", 32'(obf_n), 32'h7);
        check("rst_intr", 32'(intr), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_d_oe", 32'(d_oe), 32'h0);
        reset_n = 1'b1;
        tick();

        // Register-level table: mode-0 I/O, status, out-of-range addresses.
        tbl[0]  = '{1'b0, 3'd1, 8'h00, 8'h01};
        tbl[1]  = '{1'b1, 3'd1, 8'h00, 8'h00};
        tbl[2]  = '{1'b1, 3'd0, 8'hA5, 8'h00};
        tbl[3]  = '{1'b0, 3'd0, 8'h00, 8'hA5};
        tbl[4]  = '{1'b0, 3'd1, 8'h00, 8'h00};
        tbl[5]  = '{1'b1, 3'd3, 8'h00, 8'h00};
        tbl[6]  = '{1'b1, 3'd2, 8'h77, 8'h00};
        tbl[7]  = '{1'b0, 3'd2, 8'h00, 8'h77};
        tbl[8]  = '{1'b1, 3'd3, 8'h01, 8'h00};
        tbl[9]  = '{1'b0, 3'd3, 8'h00, 8'h01};
        tbl[10] = '{1'b0, 3'd2, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 3'd6, 8'h00, 8'h00};
        tbl[12] = '{1'b1, 3'd6, 8'hFF, 8'h00};
        tbl[13] = '{1'b0, 3'd7, 8'h00, 8'h00};
        tbl[14] = '{1'b0, 3'd0, 8'h00, 8'hA5};
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].is_wr) cpu_write(tbl[i].a, tbl[i].d);
            else begin
                cpu_read(tbl[i].a, rv);
                check($sformatf("table_rd_%0d", i), 32'(rv), 32'(tbl[i].exp));
            end
        end

        // Mode 0 output visible right after the write commit edge.
        cpu_write(3'd1, 8'h00);
        cpu_write(3'd0, 8'h5C);
        check("m0_port_out", 32'(port_out[7:0]), 32'h5C);
        check("m0_port_oe", 32'(port_oe[7:0]), 32'hFF);

        // Mode 1 input on port 1: strobe latency and read-clears-IBF.
        cpu_write(3'd3, 8'h07);
        port_in[15:8] = 8'h3C;
        tick(); tick();
        stb_n[1] = 1'b0;
        tick();
        tick();
        check("m1in_ibf_k1", 32'(ibf[1]), 32'h0);
        tick();
        check("m1in_ibf_k2", 32'(ibf[1]), 32'h1);
        check("m1in_intr_k2", 32'(intr[1]), 32'h1);
        stb_n[1] = 1'b1;
        cpu_read(3'd2, rv);
        check("m1in_data", 32'(rv), 32'h3C);
        check("m1in_ibf_clr", 32'(ibf[1]), 32'h0);
        check("m1in_intr_clr", 32'(intr[1]), 32'h0);
        tick();
        check("d_oe_release", 32'(d_oe), 32'h0);
        check("dout_hold", 32'(dout), 32'h3C);

        // Mode 1 output on port 0: OBF, ack fall/rise, done interrupt.
        cpu_write(3'd1, 8'h06);
        cpu_write(3'd0, 8'h5A);
        check("m1out_obf_set", 32'(obf_n[0]), 32'h0);
        check("m1out_port_out", 32'(port_out[7:0]), 32'h5A);
        ack_n[0] = 1'b0;
        tick(); tick();
        check("m1out_obf_k1", 32'(obf_n[0]), 32'h0);
        tick();
        check("m1out_obf_ack", 32'(obf_n[0]), 32'h1);
        check("m1out_intr_pre", 32'(intr[0]), 32'h0);
        ack_n[0] = 1'b1;
        tick(); tick(); tick();
        check("m1out_intr_done", 32'(intr[0]), 32'h1);
        cpu_read(3'd1, rv);
        check("m1out_status", 32'(rv), 32'h26);
        cpu_write(3'd0, 8'h11);
        check("m1out_intr_wrclr", 32'(intr[0]), 32'h0);
        check("m1out_obf_again", 32'(obf_n[0]), 32'h0);

        // Strobe edge colliding with a DATA read on port 1.
        port_in[15:8] = 8'h11;
        tick(); tick();
        stb_n[1] = 1'b0;
        tick(); tick(); tick();
        stb_n[1] = 1'b1;
        check("coll_first_ibf", 32'(ibf[1]), 32'h1);
        port_in[15:8] = 8'h22;
        tick(); tick(); tick();
        stb_n[1] = 1'b0;
        tick();
        cpu_read(3'd2, rv);
        check("coll_old_data", 32'(rv), 32'h11);
        check("coll_ibf_stays", 32'(ibf[1]), 32'h1);
        stb_n[1] = 1'b1;
        cpu_read(3'd2, rv);
        check("coll_new_data", 32'(rv), 32'h22);
        check("coll_ibf_clr", 32'(ibf[1]), 32'h0);

        // Held write strobe commits exactly once.
        cpu_write(3'd1, 8'h00);
        tick();
        addr = 3'd0; din = 8'hC3; cs_n = 1'b0; wr_n = 1'b0;
        tick();
        check("held_wr_first", 32'(port_out[7:0]), 32'hC3);
        din = 8'h3C;
        tick(); tick(); tick();
        check("held_wr_once", 32'(port_out[7:0]), 32'hC3);
        cs_n = 1'b1; wr_n = 1'b1;

        // rd_n and wr_n low together does nothing.
        tick();
        addr = 3'd0; din = 8'hFF; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        tick(); tick();
        check("rdwr_no_write", 32'(port_out[7:0]), 32'hC3);
        check("rdwr_no_read", 32'(d_oe), 32'h0);
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;

        // Asynchronous reset in the middle of an output handshake.
        cpu_write(3'd1, 8'h06);
        cpu_write(3'd0, 8'h5A);
        check("async_pre_obf", 32'(obf_n[0]), 32'h0);
        check("async_pre_oe", 32'(port_oe[7:0]), 32'hFF);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_obf_n", 32'(obf_n), 32'h7);
        check("async_port_oe", 32'(port_oe), 32'h0);
        check("async_port_out", 32'(port_out), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Random CPU traffic against a register-level model (strobes idle).
        for (int q = 0; q < NP; q++) begin
            m_ctrl[q] = 3'b001; m_out[q] = '0; m_obf[q] = 1'b0;
        end
        for (int n = 0; n < 200; n++) begin
            port_in = (NP*W)'($urandom);
            tick(); tick();
            p     = $urandom_range(0, NP);
            is_wr = $urandom_range(0, 1);
            sel   = $urandom_range(0, 1);
            d     = W'($urandom);
            a     = (p == NP) ? AW'(2*NP + sel) : AW'(2*p + sel);
            if (is_wr != 0) begin
                cpu_write(a, d);
                if (p < NP) begin
                    if (sel == 1) begin
                        m_ctrl[p] = d[2:0]; m_out[p] = '0; m_obf[p] = 1'b0;
                    end else begin
                        m_out[p] = d;
                        if (m_ctrl[p][1] && !m_ctrl[p][0]) m_obf[p] = 1'b1;
                    end
                end
            end else begin
                cpu_read(a, rv);
                if (p == NP) exp_rd = '0;
                else if (sel == 1) exp_rd = {3'b000, m_obf[p], 1'b0, m_ctrl[p]};
                else if (!m_ctrl[p][0]) exp_rd = m_out[p];
                else if (m_ctrl[p][1]) exp_rd = '0;
                else exp_rd = port_in[p*W +: W];
                check($sformatf("rand_rd_%0d_a%0d", n, a), 32'(rv), 32'(exp_rd));
            end
            for (int q = 0; q < NP; q++) begin
                e_out[q*W +: W] = m_out[q];
                e_oe[q*W +: W]  = m_ctrl[q][0] ? 8'h00 : 8'hFF;
                e_obfn[q]       = ~m_obf[q];
            end
            check($sformatf("rand_port_out_%0d", n), 32'(port_out), 32'(e_out));
            check($sformatf("rand_port_oe_%0d", n), 32'(port_oe), 32'(e_oe));
            check($sformatf("rand_obf_n_%0d", n), 32'(obf_n), 32'(e_obfn));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
